// File: rtl/ncl_addr_stage.sv
// ncl_addr_stage: dual-rail address stage with phase gating, FIFO buffer and clocked NCL handshakes
module ncl_addr_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int PHASE_SEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 ph0_in,
  input  logic [2*WIDTH-1:0]         addr_in,
  output logic                       ack,
  output logic [2*WIDTH-1:0]         addr_out,
  input  logic                       ack_in,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       gated,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam bit PS = PHASE_SEL != 0;
  typedef enum logic {IN_DATA, IN_NULL} in_t;
  typedef enum logic [1:0] {OUT_NULL, OUT_DATA, OUT_RTZ} out_t;
  in_t in_st, in_nx;
  out_t out_st, out_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [WIDTH-1:0] t_rails, head;
  logic [2*WIDTH-1:0] enc, addr_nx;
  logic data_w, null_w, ill_w, push, pop, ack_nx, gated_nx;
  assign head = mem[rd];
  assign null_w = ~|{addr_in, ph0_in};
  // Completion covers every address pair plus the phase token.
  always_comb begin
    data_w = ph0_in[1] ^ ph0_in[0];
    ill_w = &ph0_in;
    t_rails = '0;
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      data_w = data_w & (addr_in[2*i+1] ^ addr_in[2*i]);
      ill_w = ill_w | (&addr_in[2*i+:2]);
      t_rails[i] = addr_in[2*i+1];
      enc[2*i+1] = head[i];
      enc[2*i] = ~head[i];
    end
  end
  always_comb begin
    in_nx = in_st;
    ack_nx = ack;
    push = 1'b0;
    gated_nx = 1'b0;
    if (in_st == IN_DATA && data_w) begin
      if (!ph0_in[PS]) begin
        ack_nx = 1'b1;
        gated_nx = 1'b1;
        in_nx = IN_NULL;
      end else if (count < FULL) begin
        push = 1'b1;
        ack_nx = 1'b1;
        in_nx = IN_NULL;
      end
    end else if (in_st == IN_NULL && null_w) begin
      ack_nx = 1'b0;
      in_nx = IN_DATA;
    end
  end
  always_comb begin
    out_nx = out_st;
    addr_nx = addr_out;
    pop = 1'b0;
    case (out_st)
      OUT_NULL: if (!ack_in && count != '0) begin
        addr_nx = enc;
        out_nx = OUT_DATA;
      end
      OUT_DATA: if (ack_in) begin
        addr_nx = '0;
        pop = 1'b1;
        out_nx = OUT_RTZ;
      end
      OUT_RTZ: out_nx = ack_in ? OUT_RTZ : OUT_NULL;
      default: begin
        addr_nx = '0;
        out_nx = OUT_NULL;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      in_st <= IN_DATA;
      out_st <= OUT_NULL;
      ack <= 1'b0;
      gated <= 1'b0;
      err <= 1'b0;
      addr_out <= '0;
      count <= '0;
      wr <= '0;
      rd <= '0;
    end else begin
      in_st <= in_nx;
      out_st <= out_nx;
      ack <= ack_nx;
      gated <= gated_nx;
      err <= err | ill_w;
      addr_out <= addr_nx;
      count <= count + CW'(push) - CW'(pop);
      wr <= push ? wr + AW'(1) : wr;
      rd <= pop ? rd + AW'(1) : rd;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr] <= t_rails;
endmodule

// File: tb/tb_ncl_addr_stage.sv
// tb_ncl_addr_stage: scoreboard-driven checks of the dual-rail address stage
module tb_ncl_addr_stage;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, ack_in = 1'b1, ack, gated, err;
  logic [1:0] ph0_in = 2'b00;
  logic [2*W-1:0] addr_in = '0, addr_out;
  logic [1:0] count;
  logic [W-1:0] exp_q [$];
  int tests = 0, fails = 0;

  ncl_addr_stage #(.WIDTH(W), .DEPTH(2), .PHASE_SEL(1)) dut (
    .clk(clk), .rst(rst), .ph0_in(ph0_in), .addr_in(addr_in), .ack(ack),
    .addr_out(addr_out), .ack_in(ack_in), .count(count), .gated(gated), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] dr(input logic [W-1:0] v);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = v[i];
      r[2*i] = ~v[i];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ph, input logic [W-1:0] v);
    ph0_in = ph;
    addr_in = dr(v);
  endtask

  task automatic drive_null();
    ph0_in = 2'b00;
    addr_in = '0;
  endtask

  task automatic expect_out(input string name);
    logic [W-1:0] e;
    int n = 0;
    while (addr_out == '0 && n < 4) begin
      step();
      n++;
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: output %h seen with empty scoreboard", name, addr_out);
    end else begin
      e = exp_q.pop_front();
      if (addr_out !== dr(e)) begin
        fails++;
        $display("FAIL %s: addr_out=%h expected %h", name, addr_out, dr(e));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ph0_in = 2'($urandom);
      addr_in = 8'($urandom);
      ack_in = 1'($urandom);
      step();
    end
    tests++; if (addr_out !== '0) begin fails++; $display("FAIL reset_addr: %h expected 0", addr_out); end
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack: %b expected 0", ack); end
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL reset_count: %0d expected 0", count); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: %b expected 0", err); end
    tests++; if (gated !== 1'b0) begin fails++; $display("FAIL reset_gated: %b expected 0", gated); end
    drive_null();
    ack_in = 1'b1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    ack_in = 1'b0;
    drive(2'b10, 4'hA);
    exp_q.push_back(4'hA);
    step();
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL single_ack: %b expected 1", ack); end
    tests++; if (addr_out !== '0) begin fails++; $display("FAIL single_lat: %h expected 0", addr_out); end
    step();
    tests++; if (addr_out !== 8'b10011001) begin fails++; $display("FAIL single_enc: %h expected 99", addr_out); end
    expect_out("single_out");
    ack_in = 1'b1;
    step();
    tests++; if (addr_out !== '0) begin fails++; $display("FAIL single_rtz: %h expected 0", addr_out); end
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL single_count: %0d expected 0", count); end
    drive_null();
    step();
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL single_null_ack: %b expected 0", ack); end
  endtask

  task automatic test_full_stall();
    logic [W-1:0] vals [2] = '{4'h3, 4'h5};
    ack_in = 1'b1;
    foreach (vals[i]) begin
      drive(2'b10, vals[i]);
      exp_q.push_back(vals[i]);
      step();
      tests++; if (ack !== 1'b1) begin fails++; $display("FAIL full_push_ack: %b expected 1", ack); end
      drive_null();
      step();
    end
    tests++; if (count !== 2'd2) begin fails++; $display("FAIL full_count: %0d expected 2", count); end
    drive(2'b10, 4'h7);
    exp_q.push_back(4'h7);
    step();
    step();
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL full_stall_ack: %b expected 0", ack); end
    tests++; if (count !== 2'd2) begin fails++; $display("FAIL full_stall_count: %0d expected 2", count); end
    for (int k = 0; k < 3; k++) begin
      ack_in = 1'b0;
      step();
      expect_out("full_order");
      ack_in = 1'b1;
      step();
      tests++; if (addr_out !== '0) begin fails++; $display("FAIL full_rtz: %h expected 0", addr_out); end
      if (k == 0) begin
        tests++; if (count !== 2'd1 || ack !== 1'b0) begin fails++; $display("FAIL full_drop: count=%0d ack=%b expected 1/0", count, ack); end
        step();
        tests++; if (ack !== 1'b1 || count !== 2'd2) begin fails++; $display("FAIL full_accept: ack=%b count=%0d expected 1/2", ack, count); end
        drive_null();
        step();
      end
    end
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL full_drain: %0d expected 0", count); end
    ack_in = 1'b0;
    step();
  endtask

  task automatic test_gated();
    drive(2'b01, 4'h6);
    step();
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL gated_ack: %b expected 1", ack); end
    tests++; if (gated !== 1'b1) begin fails++; $display("FAIL gated_pulse: %b expected 1", gated); end
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL gated_count: %0d expected 0", count); end
    step();
    tests++; if (gated !== 1'b0) begin fails++; $display("FAIL gated_one_cycle: %b expected 0", gated); end
    tests++; if (addr_out !== '0) begin fails++; $display("FAIL gated_out: %h expected 0", addr_out); end
    drive_null();
    step();
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL gated_null_ack: %b expected 0", ack); end
  endtask

  task automatic test_illegal();
    drive(2'b10, 4'h6);
    addr_in[1:0] = 2'b11;
    step();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err: %b expected 1", err); end
    tests++; if (ack !== 1'b0 || count !== 2'd0) begin fails++; $display("FAIL illegal_accept: ack=%b count=%0d expected 0/0", ack, count); end
    drive_null();
    step();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_sticky: %b expected 1", err); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL illegal_clear: %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    ack_in = 1'b0;
    drive(2'b10, 4'h9);
    exp_q.push_back(4'h9);
    step();
    step();
    expect_out("mid_first");
    tests++; if (count !== 2'd1) begin fails++; $display("FAIL mid_count: %0d expected 1", count); end
    rst = 1'b1;
    drive_null();
    step();
    tests++; if (addr_out !== '0 || count !== 2'd0 || ack !== 1'b0) begin fails++; $display("FAIL mid_reset: addr=%h count=%0d ack=%b expected 0/0/0", addr_out, count, ack); end
    drive(2'b10, 4'hC);
    step();
    rst = 1'b0;
    exp_q.push_back(4'hC);
    step();
    tests++; if (ack !== 1'b1 || count !== 2'd1) begin fails++; $display("FAIL mid_release: ack=%b count=%0d expected 1/1", ack, count); end
    step();
    expect_out("mid_no_stale");
    ack_in = 1'b1;
    drive_null();
    step();
    step();
    tests++; if (count !== 2'd0 || exp_q.size() != 0) begin fails++; $display("FAIL mid_drain: count=%0d queue=%0d expected 0/0", count, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_stall();
    test_gated();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
